// File: rtl/hazard_ctrl_pipe.sv
// Stall, kill and operand-forward control for the 5-stage F/D/X/M/W pipeline.
// The block tracks per-stage valid bits and keeps saturating stall, flush and retire counters.
module hazard_ctrl_pipe #(
    parameter int REG_AW     = 5,
    parameter int FWD_EN     = 1,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_use_rs1,
    input  logic              d_use_rs2,
    input  logic [REG_AW-1:0] x_rd,
    input  logic [REG_AW-1:0] m_rd,
    input  logic              x_wen,
    input  logic              m_wen,
    input  logic              x_is_load,
    input  logic              x_busy,
    input  logic              x_redirect,
    output logic              pc_en,
    output logic              fd_en,
    output logic              v_d,
    output logic              v_x,
    output logic              v_m,
    output logic              v_w,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic       x_w, m_w;
    logic       raw_x, raw_m;
    logic       load_use, raw_stall;
    logic       redirect, busy, stall;
    logic [1:0] stall_q;
    logic [1:0] sel_a, sel_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // A writer only counts when its stage holds a real instruction writing a non-zero rd.
    assign x_w = v_x && x_wen && (x_rd != '0);
    assign m_w = v_m && m_wen && (m_rd != '0);

    assign raw_x = x_w && ((d_use_rs1 && (d_rs1 == x_rd)) || (d_use_rs2 && (d_rs2 == x_rd)));
    assign raw_m = m_w && ((d_use_rs1 && (d_rs1 == m_rd)) || (d_use_rs2 && (d_rs2 == m_rd)));

    assign load_use  = v_d && raw_x && x_is_load;
    assign raw_stall = (FWD_EN == 0) && v_d && (raw_x || raw_m);

    assign redirect = x_redirect && v_x;
    assign busy     = x_busy && v_x && !redirect;
    // A non-zero stall counter keeps the load-use bubble going after the load left X.
    assign stall    = !redirect && !busy && (load_use || raw_stall || (stall_q != 2'd0));

    assign pc_en = rst || !(busy || stall);
    assign fd_en = rst || !(busy || stall);

    always_comb begin
        sel_a = 2'd0;
        sel_b = 2'd0;
        if (FWD_EN != 0) begin
            if (d_use_rs1 && x_w && !x_is_load && (d_rs1 == x_rd))
                sel_a = 2'd1;
            else if (d_use_rs1 && m_w && (d_rs1 == m_rd))
                sel_a = 2'd2;
            if (d_use_rs2 && x_w && !x_is_load && (d_rs2 == x_rd))
                sel_b = 2'd1;
            else if (d_use_rs2 && m_w && (d_rs2 == m_rd))
                sel_b = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_d        <= 1'b0;
            v_x        <= 1'b0;
            v_m        <= 1'b0;
            v_w        <= 1'b0;
            fwd_a_sel  <= 2'd0;
            fwd_b_sel  <= 2'd0;
            stall_q    <= 2'd0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (redirect) begin
                v_d       <= 1'b0;
                v_x       <= 1'b0;
                v_m       <= 1'b1;
                v_w       <= v_m;
                fwd_a_sel <= 2'd0;
                fwd_b_sel <= 2'd0;
                stall_q   <= 2'd0;
                flush_cnt <= sat_inc(flush_cnt);
            end else if (busy) begin
                v_m       <= 1'b0;
                v_w       <= v_m;
                stall_cnt <= sat_inc(stall_cnt);
            end else if (stall) begin
                v_x       <= 1'b0;
                v_m       <= v_x;
                v_w       <= v_m;
                fwd_a_sel <= 2'd0;
                fwd_b_sel <= 2'd0;
                stall_cnt <= sat_inc(stall_cnt);
                if (stall_q != 2'd0)
                    stall_q <= stall_q - 2'd1;
                else if (load_use)
                    stall_q <= 2'(LOAD_STALL - 1);
            end else begin
                v_d       <= 1'b1;
                v_x       <= v_d;
                v_m       <= v_x;
                v_w       <= v_m;
                fwd_a_sel <= v_d ? sel_a : 2'd0;
                fwd_b_sel <= v_d ? sel_b : 2'd0;
            end
            if (v_w)
                retire_cnt <= sat_inc(retire_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe: a forwarding core with two load bubbles, a
// no-forwarding core, and a narrow-counter core for saturation, all fed the same inputs.
module tb_hazard_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] d_rs1, d_rs2, x_rd, m_rd;
    logic       d_use_rs1, d_use_rs2, x_wen, m_wen, x_is_load, x_busy, x_redirect;

    logic        dut_pc_en, dut_fd_en;
    logic [3:0]  dut_v;
    logic [1:0]  dut_fa, dut_fb;
    logic [15:0] dut_stall, dut_flush, dut_retire;

    logic        nof_pc_en, nof_fd_en;
    logic [3:0]  nof_v;
    logic [1:0]  nof_fa, nof_fb;
    logic [15:0] nof_stall, nof_flush, nof_retire;

    logic        sat_pc_en, sat_fd_en;
    logic [3:0]  sat_v;
    logic [1:0]  sat_fa, sat_fb;
    logic [3:0]  sat_stall, sat_flush, sat_retire;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_pipe #(.REG_AW(5), .FWD_EN(1), .LOAD_STALL(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1),
        .d_use_rs2(d_use_rs2), .x_rd(x_rd), .m_rd(m_rd), .x_wen(x_wen), .m_wen(m_wen),
        .x_is_load(x_is_load), .x_busy(x_busy), .x_redirect(x_redirect),
        .pc_en(dut_pc_en), .fd_en(dut_fd_en), .v_d(dut_v[3]), .v_x(dut_v[2]),
        .v_m(dut_v[1]), .v_w(dut_v[0]), .fwd_a_sel(dut_fa), .fwd_b_sel(dut_fb),
        .stall_cnt(dut_stall), .flush_cnt(dut_flush), .retire_cnt(dut_retire)
    );

    hazard_ctrl_pipe #(.REG_AW(5), .FWD_EN(0), .LOAD_STALL(1), .CNT_W(16)) u_nof (
        .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1),
        .d_use_rs2(d_use_rs2), .x_rd(x_rd), .m_rd(m_rd), .x_wen(x_wen), .m_wen(m_wen),
        .x_is_load(x_is_load), .x_busy(x_busy), .x_redirect(x_redirect),
        .pc_en(nof_pc_en), .fd_en(nof_fd_en), .v_d(nof_v[3]), .v_x(nof_v[2]),
        .v_m(nof_v[1]), .v_w(nof_v[0]), .fwd_a_sel(nof_fa), .fwd_b_sel(nof_fb),
        .stall_cnt(nof_stall), .flush_cnt(nof_flush), .retire_cnt(nof_retire)
    );

    hazard_ctrl_pipe #(.REG_AW(5), .FWD_EN(1), .LOAD_STALL(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1),
        .d_use_rs2(d_use_rs2), .x_rd(x_rd), .m_rd(m_rd), .x_wen(x_wen), .m_wen(m_wen),
        .x_is_load(x_is_load), .x_busy(x_busy), .x_redirect(x_redirect),
        .pc_en(sat_pc_en), .fd_en(sat_fd_en), .v_d(sat_v[3]), .v_x(sat_v[2]),
        .v_m(sat_v[1]), .v_w(sat_v[0]), .fwd_a_sel(sat_fa), .fwd_b_sel(sat_fb),
        .stall_cnt(sat_stall), .flush_cnt(sat_flush), .retire_cnt(sat_retire)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_rs1 = '0; d_rs2 = '0; x_rd = '0; m_rd = '0;
        d_use_rs1 = 1'b0; d_use_rs2 = 1'b0; x_wen = 1'b0; m_wen = 1'b0;
        x_is_load = 1'b0; x_busy = 1'b0; x_redirect = 1'b0;
    endtask

    // Leaves every instance with a full pipeline (1111) and zeroed counters.
    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        // Reset and pipeline fill
        idle();
        rst = 1'b1;
        repeat (3) tick();
        check("rst_v", dut_v, 4'b0000);
        check("rst_pc_en", dut_pc_en, 1'b1);
        check("rst_fd_en", dut_fd_en, 1'b1);
        check("rst_stall", dut_stall, 16'd0);
        check("rst_flush", dut_flush, 16'd0);
        check("rst_retire", dut_retire, 16'd0);
        check("rst_fa", dut_fa, 2'd0);
        rst = 1'b0;
        tick();
        check("rel_v", dut_v, 4'b1000);
        repeat (3) tick();
        check("full_v", dut_v, 4'b1111);
        check("full_retire", dut_retire, 16'd0);

        // Forward selects
        x_rd = 5'd5; x_wen = 1'b1; d_rs1 = 5'd5; d_use_rs1 = 1'b1;
        #1 check("fx_pc_en", dut_pc_en, 1'b1);
        tick();
        check("fx_fa", dut_fa, 2'd1);
        x_wen = 1'b0; m_rd = 5'd5; m_wen = 1'b1;
        #1 check("fm_pc_en", dut_pc_en, 1'b1);
        tick();
        check("fm_fa", dut_fa, 2'd2);
        x_wen = 1'b1;
        tick();
        check("x_over_m_fa", dut_fa, 2'd1);
        x_rd = 5'd0; m_wen = 1'b0; d_rs1 = 5'd0;
        tick();
        check("x0_fa", dut_fa, 2'd0);
        x_rd = 5'd5; d_rs1 = 5'd5; d_use_rs1 = 1'b0;
        tick();
        check("no_use_fa", dut_fa, 2'd0);
        x_wen = 1'b0; d_rs2 = 5'd9; d_use_rs2 = 1'b1; m_rd = 5'd9; m_wen = 1'b1;
        tick();
        check("fm_fb", dut_fb, 2'd2);
        check("fwd_retire", dut_retire, 16'd6);

        // Load-use: u_dut has two bubbles, u_sat one
        do_reset();
        x_rd = 5'd7; x_wen = 1'b1; x_is_load = 1'b1; d_rs2 = 5'd7; d_use_rs2 = 1'b1;
        #1;
        check("ld1_pc_en", dut_pc_en, 1'b0);
        check("ld1_fd_en", dut_fd_en, 1'b0);
        check("ld1_sat_pc_en", sat_pc_en, 1'b0);
        tick();
        check("ld1_v", dut_v, 4'b1011);
        check("ld1_stall", dut_stall, 16'd1);
        x_wen = 1'b0; x_is_load = 1'b0; m_rd = 5'd7; m_wen = 1'b1;
        #1;
        check("ld2_pc_en", dut_pc_en, 1'b0);
        check("ld2_sat_pc_en", sat_pc_en, 1'b1);
        tick();
        check("ld2_v", dut_v, 4'b1001);
        check("ld2_stall", dut_stall, 16'd2);
        // With one bubble the consumer meets the load in M.
        check("ld_sat_vx", sat_v[2], 1'b1);
        check("ld_sat_fb", sat_fb, 2'd2);
        m_wen = 1'b0;
        #1 check("ld3_pc_en", dut_pc_en, 1'b1);
        tick();
        check("ld3_v", dut_v, 4'b1100);
        // Load is in W by now; the register file's write-through supplies the value.
        check("ld3_fb", dut_fb, 2'd0);
        check("ld3_stall", dut_stall, 16'd2);

        // Redirect beats busy
        do_reset();
        x_redirect = 1'b1; x_busy = 1'b1;
        #1 check("rd_pc_en", dut_pc_en, 1'b1);
        tick();
        check("rd_v", dut_v, 4'b0011);
        check("rd_flush", dut_flush, 16'd1);
        check("rd_stall", dut_stall, 16'd0);
        check("rd_retire", dut_retire, 16'd1);
        idle();
        tick();
        check("rd_after_v", dut_v, 4'b1001);

        // Multi-cycle X unit busy for 5 cycles
        do_reset();
        x_rd = 5'd5; x_wen = 1'b1; d_rs1 = 5'd5; d_use_rs1 = 1'b1;
        tick();
        check("bz_pre_fa", dut_fa, 2'd1);
        idle();
        x_busy = 1'b1;
        #1;
        check("bz_pc_en", dut_pc_en, 1'b0);
        check("bz_fd_en", dut_fd_en, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bz_vm_%0d", i), dut_v[1], 1'b0);
        end
        check("bz_v", dut_v, 4'b1100);
        check("bz_stall", dut_stall, 16'd5);
        check("bz_fa_hold", dut_fa, 2'd1);
        check("bz_retire", dut_retire, 16'd3);
        x_busy = 1'b0;
        tick();
        check("bz_end_v", dut_v, 4'b1110);
        check("bz_end_fa", dut_fa, 2'd0);

        // No forwarding: RAW with X then with M stalls twice
        do_reset();
        x_rd = 5'd3; x_wen = 1'b1; d_rs1 = 5'd3; d_use_rs1 = 1'b1;
        #1 check("nf1_pc_en", nof_pc_en, 1'b0);
        tick();
        check("nf1_v", nof_v, 4'b1011);
        check("nf1_stall", nof_stall, 16'd1);
        x_wen = 1'b0; m_rd = 5'd3; m_wen = 1'b1;
        #1 check("nf2_pc_en", nof_pc_en, 1'b0);
        tick();
        check("nf2_v", nof_v, 4'b1001);
        check("nf2_stall", nof_stall, 16'd2);
        m_wen = 1'b0;
        #1 check("nf3_pc_en", nof_pc_en, 1'b1);
        tick();
        check("nf3_v", nof_v, 4'b1100);
        check("nf3_fa", nof_fa, 2'd0);
        check("nf3_stall", nof_stall, 16'd2);

        // Counter saturation on the 4-bit instance
        do_reset();
        repeat (20) tick();
        check("sat_retire", sat_retire, 4'hF);
        x_busy = 1'b1;
        repeat (20) tick();
        check("sat_stall", sat_stall, 4'hF);
        x_busy = 1'b0; x_redirect = 1'b1;
        repeat (60) tick();
        check("sat_flush", sat_flush, 4'hF);
        check("sat_retire_hold", sat_retire, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
